// File: rtl/mouse_report_scheduler_if.sv
// Byte-stream handshake between the report scheduler and the PS/2 serializer.
interface mouse_report_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/mouse_report_scheduler.sv
// Periodic PS/2 mouse report generator: samples direction/magnitude/button flags on a
// timer tick and streams a 3-byte movement packet over a valid/ready byte interface.
module mouse_report_scheduler #(
  parameter int unsigned REPORT_DIV    = 500000,
  parameter bit          SUPPRESS_IDLE = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            click,
  input  logic                            izquierda,
  input  logic                            derecha,
  input  logic                            arriba,
  input  logic                            abajo,
  input  logic [7:0]                      mag_x,
  input  logic [7:0]                      mag_y,
  mouse_report_scheduler_if.master        tx,
  output logic                            busy,
  output logic [7:0]                      missed
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned D_W    = 9;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, SEND0, SEND1, SEND2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               tick_c;
  logic [D_W-1:0]     dx_c, dy_c;
  logic [D_W-1:0]     dx_q, dx_d, dy_q, dy_d;
  logic               click_q, click_d;
  logic               last_click_q, last_click_d;
  logic [BYTE_W-1:0]  missed_q, missed_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q;
  logic               accept_c;

  assign tick_c      = enable && (cnt_q == CNT_W'(REPORT_DIV - 1));
  assign accept_c    = tx_valid_q && tx.tx_ready;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign missed      = missed_q;

  // Report period timer; parked at zero while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!enable || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Signed displacement; opposing flags cancel.
  always_comb begin
    dx_c = '0;
    dy_c = '0;
    if (derecha && !izquierda)      dx_c = {1'b0, mag_x};
    else if (izquierda && !derecha) dx_c = -{1'b0, mag_x};
    if (arriba && !abajo)           dy_c = {1'b0, mag_y};
    else if (abajo && !arriba)      dy_c = -{1'b0, mag_y};
  end

  // Next state, snapshot, drop counter and next output byte.
  always_comb begin
    state_d      = state_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    click_d      = click_q;
    last_click_d = last_click_q;
    missed_d     = missed_q;
    tx_data_d    = '0;
    tx_valid_d   = 1'b0;

    if (tick_c && (state_q != IDLE) && (missed_q != 8'hFF)) begin
      missed_d = missed_q + BYTE_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (tick_c) begin
          dx_d    = dx_c;
          dy_d    = dy_c;
          click_d = click;
          if (!(SUPPRESS_IDLE && (dx_c == '0) && (dy_c == '0) && (click == last_click_q))) begin
            state_d = SEND0;
          end
        end
      end
      SEND0: if (accept_c) state_d = SEND1;
      SEND1: if (accept_c) state_d = SEND2;
      SEND2: begin
        if (accept_c) begin
          state_d      = IDLE;
          last_click_d = click_q;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      SEND0:   tx_data_d = {2'b00, dy_d[D_W-1], dx_d[D_W-1], 1'b1, 2'b00, click_d};
      SEND1:   tx_data_d = dx_d[BYTE_W-1:0];
      SEND2:   tx_data_d = dy_d[BYTE_W-1:0];
      default: tx_data_d = '0;
    endcase
    tx_valid_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dx_q         <= '0;
      dy_q         <= '0;
      click_q      <= 1'b0;
      last_click_q <= 1'b0;
      missed_q     <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      click_q      <= click_d;
      last_click_q <= last_click_d;
      missed_q     <= missed_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= (state_d != IDLE);
    end
  end

endmodule
